pixel_fetch_arb: RTL and testbench
==================================

// Module: pixel_fetch_arb
// PURPOSE
//  Sequences both pixel ROMs (background 320x240 scaled x2, alphabet glyph sheet) for the VGA path.
//  Computes ROM addresses from h_cnt/v_cnt and the glyph window, and compensates ROM read latency.
//  Shares the ROM ports with one auxiliary reader (game logic) during blanking via req/gnt.
//  Sits between the VGA timing controller and the block ROMs; its pixel output feeds the RGB regs.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  V_ACTIVE  480  visible lines
//  ROM_LAT   1    block-ROM read latency in clk cycles (1..3)
//  GLYPH_N   26   glyph count in alphabet ROM (32x32 each, 1024 words per glyph)
//  KEY_COLOR 12'h0F0  transparent colour in alphabet ROM (used with PIXEL_KEY_EN)
// PORTS
//  clk         in   1   pixel clock, same clock as both ROMs
//  rst_n       in   1   asynchronous reset, active low
//  h_cnt       in   10  horizontal counter from VGA controller
//  v_cnt       in   10  vertical counter from VGA controller
//  valid       in   1   VGA active-video flag
//  glyph_en    in   1   alphabet window enabled
//  glyph_x     in   10  window left column;  glyph_y in 10 window top row
//  glyph_idx   in   5   glyph index to draw
//  bg_addr     out  17  background ROM address;  bg_dout in 12 background ROM data
//  al_addr     out  16  alphabet ROM address;    al_dout in 12 alphabet ROM data
//  aux_req     in   1   aux read request (level, held until aux_gnt)
//  aux_sel     in   1   0 = background ROM, 1 = alphabet ROM
//  aux_addr    in   17  aux address (alphabet uses [15:0])
//  aux_gnt     out  1   one-cycle pulse: aux address issued this cycle
//  aux_rvalid  out  1   one-cycle pulse: aux_rdata valid
//  aux_rdata   out  12  aux read data, held until next aux_rvalid
//  pixel       out  12  RGB444 pixel;  pixel_valid out 1 delayed valid
// BEHAVIOUR
//  - Reset: all outputs 0, aux FSM IDLE, latency pipelines flushed; in-flight aux read dropped (no rvalid).
//  - Stage 0 (registered): eff_valid = valid & h_cnt<H_ACTIVE & v_cnt<V_ACTIVE.
//    bg_addr = (v_cnt>>1)*320 + (h_cnt>>1).
//    in_win = glyph_en & glyph_idx<GLYPH_N & h-glyph_x in [0,31] & v-glyph_y in [0,31] (11-bit math, no wrap).
//    al_addr = glyph_idx*1024 + (v-glyph_y)*32 + (h-glyph_x).
//  - Display latency: pixel/pixel_valid appear exactly 1+ROM_LAT cycles after h/v/valid sample.
//    in_win and eff_valid travel in a matching delay line.
//  - pixel = !eff_valid_d ? 0 : in_win_d ? al_dout : bg_dout.
//  - Arbitration: display owns both ROM ports whenever valid=1 (fixed priority, no aux issue).
//  - Aux FSM: IDLE -> (aux_req & !valid) ISSUE -> WAIT (ROM_LAT cycles) -> DONE -> IDLE.
//    ISSUE drives the selected ROM address from aux_addr and pulses aux_gnt.
//    DONE captures aux_rdata and pulses aux_rvalid, exactly 1+ROM_LAT cycles after aux_gnt.
//    An aux read issued in the last blanking cycle completes even if valid rises; display output unaffected.
//    Max one aux read outstanding; aux_req high in DONE is re-arbitrated in IDLE next cycle.
//  - aux_req ignored while valid=1; it is sampled again at the first blanking cycle.
// CONFIGURATION
//  PIXEL_KEY_EN defined: inside window, al_dout==KEY_COLOR shows bg_dout (transparent glyph background).
//  PIXEL_KEY_EN undefined: inside window always shows al_dout; KEY_COLOR unused.
// STRUCTURE
//  pixel_fetch_pkg: H_ACTIVE/V_ACTIVE defaults, BG_W=320, GLYPH_SZ=32, aux FSM state encoding.
//  Sub-module pipe_delay (WIDTH, DEPTH): valid/in_win delay line and aux WAIT counter-free alignment.
// TESTING
//  1 h=0,v=0,valid=1, glyph_en=0 -> bg_addr=0; pixel=bg_dout after 1+ROM_LAT cycles, pixel_valid=1.
//  2 h=639,v=479 -> bg_addr=76799.  h=640 with valid=1 -> pixel=0, pixel_valid=0.
//  3 glyph_x=100, glyph_y=50, idx=2, h=131, v=81 -> al_addr=3071, in_win.  h=132 -> background.
//  4 glyph_idx=26 -> never in_win.  glyph_x=1000, h=1023 -> in_win, no wrap to column 0.
//  5 aux_req, sel=0, addr=1234, valid=0 -> aux_gnt next cycle, bg_addr=1234.
//    aux_rvalid 1+ROM_LAT later with ROM word.  Repeat with valid=1: no gnt until valid falls.
//  6 rst_n low during WAIT -> no aux_rvalid, all outputs 0.
//    Also with PIXEL_KEY_EN: al_dout=12'h0F0 -> pixel=bg_dout.

Source files
------------

// File: rtl/pixel_fetch_pkg.sv
// pixel_fetch_pkg: shared defaults, geometry constants and
// aux FSM encoding for pixel_fetch_arb.
package pixel_fetch_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int ROM_LAT_DEF  = 1;
  localparam int GLYPH_N_DEF  = 26;

  localparam logic [11:0] KEY_COLOR_DEF = 12'h0F0;

  localparam int BG_W     = 320;
  localparam int GLYPH_SZ = 32;

  typedef enum logic [1:0] {
    AUX_IDLE,
    AUX_ISSUE,
    AUX_WAIT,
    AUX_DONE
  } aux_st_e;

endpackage

// File: rtl/pipe_delay.sv
// pipe_delay: resettable shift register, DEPTH cycles deep.
// Aligns side-band flags with block-ROM read latency.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/pixel_fetch_arb.sv
// pixel_fetch_arb: background/glyph ROM sequencer with blanking-time
// aux reader. Define PIXEL_KEY_EN for transparent glyph key colour.
module pixel_fetch_arb
  import pixel_fetch_pkg::*;
#(
  parameter int          H_ACTIVE  = H_ACTIVE_DEF,
  parameter int          V_ACTIVE  = V_ACTIVE_DEF,
  parameter int          ROM_LAT   = ROM_LAT_DEF,
  parameter int          GLYPH_N   = GLYPH_N_DEF,
  parameter logic [11:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        glyph_en,
  input  logic [9:0]  glyph_x,
  input  logic [9:0]  glyph_y,
  input  logic [4:0]  glyph_idx,
  output logic [16:0] bg_addr,
  input  logic [11:0] bg_dout,
  output logic [15:0] al_addr,
  input  logic [11:0] al_dout,
  input  logic        aux_req,
  input  logic        aux_sel,
  input  logic [16:0] aux_addr,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [11:0] aux_rdata,
  output logic [11:0] pixel,
  output logic        pixel_valid
);

  logic [10:0] dx;
  logic [10:0] dy;
  logic        eff_valid;
  logic        in_win;
  logic [16:0] disp_bg;
  logic [15:0] disp_al;

  // 11-bit differences so a window near the right edge never wraps
  assign dx = {1'b0, h_cnt} - {1'b0, glyph_x};
  assign dy = {1'b0, v_cnt} - {1'b0, glyph_y};

  assign eff_valid = valid
                   & (h_cnt < 10'(H_ACTIVE))
                   & (v_cnt < 10'(V_ACTIVE));

  assign in_win = glyph_en
                & (glyph_idx < 5'(GLYPH_N))
                & (dx < 11'(GLYPH_SZ))
                & (dy < 11'(GLYPH_SZ));

  assign disp_bg = 17'(v_cnt[9:1]) * 17'(BG_W)
                 + 17'(h_cnt[9:1]);

  assign disp_al = {1'b0, glyph_idx, dy[4:0], dx[4:0]};

  aux_st_e     state_q, state_d;
  logic        aux_take;
  logic        gnt_dly;
  logic        sel_q, sel_d;
  logic [11:0] aux_rdata_q, aux_rdata_d;

  assign aux_take = (state_q == AUX_IDLE) & aux_req & ~valid;

  logic [16:0] bg_addr_q, bg_addr_d;
  logic [15:0] al_addr_q, al_addr_d;
  logic        ev_q, iw_q;

  always_comb begin
    bg_addr_d = disp_bg;
    al_addr_d = disp_al;
    if (aux_take && !aux_sel) begin
      bg_addr_d = aux_addr;
    end
    if (aux_take && aux_sel) begin
      al_addr_d = aux_addr[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_addr_q <= '0;
      al_addr_q <= '0;
      ev_q      <= 1'b0;
      iw_q      <= 1'b0;
    end else begin
      bg_addr_q <= bg_addr_d;
      al_addr_q <= al_addr_d;
      ev_q      <= eff_valid;
      iw_q      <= in_win;
    end
  end

  assign bg_addr = bg_addr_q;
  assign al_addr = al_addr_q;

  logic        ev_dly;
  logic        iw_dly;
  logic [11:0] pixel_q, pixel_d;
  logic        pv_q;

  pipe_delay #(
    .WIDTH (2),
    .DEPTH (ROM_LAT)
  ) u_disp_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({ev_q, iw_q}),
    .q_o   ({ev_dly, iw_dly})
  );

  always_comb begin
    pixel_d = 12'h000;
    if (ev_dly) begin
      pixel_d = bg_dout;
`ifdef PIXEL_KEY_EN
      if (iw_dly && (al_dout != KEY_COLOR)) begin
        pixel_d = al_dout;
      end
`else
      if (iw_dly) begin
        pixel_d = al_dout;
      end
`endif
    end
  end

`ifndef PIXEL_KEY_EN
  logic [11:0] key_unused;
  assign key_unused = KEY_COLOR;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_q <= '0;
      pv_q    <= 1'b0;
    end else begin
      pixel_q <= pixel_d;
      pv_q    <= ev_dly;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = pv_q;

  // The ISSUE pulse, delayed by the ROM latency, marks the last WAIT cycle
  pipe_delay #(
    .WIDTH (1),
    .DEPTH (ROM_LAT)
  ) u_aux_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (state_q == AUX_ISSUE),
    .q_o   (gnt_dly)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AUX_IDLE:  if (aux_take) state_d = AUX_ISSUE;
      AUX_ISSUE: state_d = AUX_WAIT;
      AUX_WAIT:  if (gnt_dly) state_d = AUX_DONE;
      AUX_DONE:  state_d = AUX_IDLE;
      default:   state_d = AUX_IDLE;
    endcase
  end

  always_comb begin
    sel_d       = sel_q;
    aux_rdata_d = aux_rdata_q;
    if (aux_take) begin
      sel_d = aux_sel;
    end
    if ((state_q == AUX_WAIT) && gnt_dly) begin
      aux_rdata_d = sel_q ? al_dout : bg_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= AUX_IDLE;
      sel_q       <= 1'b0;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  assign aux_gnt    = (state_q == AUX_ISSUE);
  assign aux_rvalid = (state_q == AUX_DONE);
  assign aux_rdata  = aux_rdata_q;

endmodule

// File: tb/tb_pixel_fetch_arb.sv
// tb_pixel_fetch_arb: directed checks of addressing, latency,
// glyph window, aux arbitration and reset for pixel_fetch_arb.
module tb_pixel_fetch_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic        valid = 1'b0;
  logic        glyph_en = 1'b0;
  logic [9:0]  glyph_x = '0;
  logic [9:0]  glyph_y = '0;
  logic [4:0]  glyph_idx = '0;
  logic [16:0] bg_addr;
  logic [11:0] bg_dout;
  logic [15:0] al_addr;
  logic [11:0] al_dout;
  logic        aux_req = 1'b0;
  logic        aux_sel = 1'b0;
  logic [16:0] aux_addr = '0;
  logic        aux_gnt;
  logic        aux_rvalid;
  logic [11:0] aux_rdata;
  logic [11:0] pixel;
  logic        pixel_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // One-cycle-latency ROM models with recognisable contents
  always_ff @(posedge clk) begin
    bg_dout <= bg_addr[11:0] ^ 12'h5A5;
    al_dout <= al_addr[11:0] ^ 12'h3C3;
  end

  pixel_fetch_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .valid       (valid),
    .glyph_en    (glyph_en),
    .glyph_x     (glyph_x),
    .glyph_y     (glyph_y),
    .glyph_idx   (glyph_idx),
    .bg_addr     (bg_addr),
    .bg_dout     (bg_dout),
    .al_addr     (al_addr),
    .al_dout     (al_dout),
    .aux_req     (aux_req),
    .aux_sel     (aux_sel),
    .aux_addr    (aux_addr),
    .aux_gnt     (aux_gnt),
    .aux_rvalid  (aux_rvalid),
    .aux_rdata   (aux_rdata),
    .pixel       (pixel),
    .pixel_valid (pixel_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bg_addr, al_addr, aux_gnt, aux_rvalid, aux_rdata,
         pixel, pixel_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: bg=%0h al=%0h gnt=%b rv=%b rd=%0h px=%0h pv=%b want all 0",
               bg_addr, al_addr, aux_gnt, aux_rvalid, aux_rdata, pixel, pixel_valid);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bg_basic();
    h_cnt = 10'd0; v_cnt = 10'd0; valid = 1'b1; glyph_en = 1'b0;
    tick();
    checks++;
    if (bg_addr !== 17'd0) begin
      errors++;
      $display("FAIL bg_addr_origin: got %0d want 0", bg_addr);
    end
    valid = 1'b0;
    tick();
    checks++;
    if (pixel_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: pixel_valid got %b want 0", pixel_valid);
    end
    tick();
    checks++;
    if (pixel !== 12'h5A5 || pixel_valid !== 1'b1) begin
      errors++;
      $display("FAIL pixel_origin: got %0h/%b want 5a5/1", pixel, pixel_valid);
    end
    tick();
    checks++;
    if (pixel_valid !== 1'b0 || pixel !== 12'h000) begin
      errors++;
      $display("FAIL pixel_after: got %0h/%b want 0/0", pixel, pixel_valid);
    end
  endtask

  task automatic test_bg_edges();
    h_cnt = 10'd639; v_cnt = 10'd479; valid = 1'b1;
    tick();
    checks++;
    if (bg_addr !== 17'd76799) begin
      errors++;
      $display("FAIL bg_addr_last: got %0d want 76799", bg_addr);
    end
    valid = 1'b0;
    tick();
    tick();
    checks++;
    if (pixel !== 12'hE5A || pixel_valid !== 1'b1) begin
      errors++;
      $display("FAIL pixel_last: got %0h/%b want e5a/1", pixel, pixel_valid);
    end
    h_cnt = 10'd640; v_cnt = 10'd0; valid = 1'b1;
    tick();
    checks++;
    if (bg_addr !== 17'd320) begin
      errors++;
      $display("FAIL bg_addr_h640: got %0d want 320", bg_addr);
    end
    valid = 1'b0;
    tick();
    tick();
    checks++;
    if (pixel !== 12'h000 || pixel_valid !== 1'b0) begin
      errors++;
      $display("FAIL pixel_h640: got %0h/%b want 0/0", pixel, pixel_valid);
    end
  endtask

  task automatic test_glyph_window();
    glyph_en = 1'b1; glyph_x = 10'd100; glyph_y = 10'd50;
    glyph_idx = 5'd2;
    h_cnt = 10'd131; v_cnt = 10'd81; valid = 1'b1;
    tick();
    checks++;
    if (al_addr !== 16'd3071) begin
      errors++;
      $display("FAIL al_addr_corner: got %0d want 3071", al_addr);
    end
    h_cnt = 10'd132;
    tick();
    checks++;
    if (bg_addr !== 17'd12866) begin
      errors++;
      $display("FAIL bg_addr_outside: got %0d want 12866", bg_addr);
    end
    h_cnt = 10'd100; v_cnt = 10'd50;
    tick();
    checks++;
    if (pixel !== 12'h83C || pixel_valid !== 1'b1) begin
      errors++;
      $display("FAIL pixel_in_win: got %0h/%b want 83c/1", pixel, pixel_valid);
    end
    valid = 1'b0;
    tick();
    checks++;
    if (pixel !== 12'h7E7) begin
      errors++;
      $display("FAIL pixel_right_of_win: got %0h want 7e7", pixel);
    end
    tick();
    checks++;
    if (pixel !== 12'hBC3) begin
      errors++;
      $display("FAIL pixel_win_topleft: got %0h want bc3", pixel);
    end
  endtask

  task automatic test_glyph_limits();
    glyph_en = 1'b1; glyph_x = 10'd100; glyph_y = 10'd50;
    glyph_idx = 5'd26;
    h_cnt = 10'd110; v_cnt = 10'd60; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    checks++;
    if (pixel !== 12'h012) begin
      errors++;
      $display("FAIL glyph_idx26: got %0h want 012", pixel);
    end
    glyph_idx = 5'd1; glyph_x = 10'd1000; glyph_y = 10'd0;
    h_cnt = 10'd1023; v_cnt = 10'd0; valid = 1'b1;
    tick();
    checks++;
    if (al_addr !== 16'd1047) begin
      errors++;
      $display("FAIL al_addr_far_right: got %0d want 1047", al_addr);
    end
    h_cnt = 10'd5;
    tick();
    valid = 1'b0;
    tick();
    tick();
    checks++;
    if (pixel !== 12'h5A7 || pixel_valid !== 1'b1) begin
      errors++;
      $display("FAIL no_wrap_col0: got %0h/%b want 5a7/1", pixel, pixel_valid);
    end
    glyph_en = 1'b0;
  endtask

  task automatic test_key();
    glyph_en = 1'b1; glyph_x = 10'd100; glyph_y = 10'd50;
    glyph_idx = 5'd4;
    h_cnt = 10'd119; v_cnt = 10'd75; valid = 1'b1;
    tick();
    checks++;
    if (al_addr !== 16'd4915) begin
      errors++;
      $display("FAIL al_addr_key: got %0d want 4915", al_addr);
    end
    valid = 1'b0;
    tick();
    tick();
    checks++;
`ifdef PIXEL_KEY_EN
    if (pixel !== 12'hBDE) begin
      errors++;
      $display("FAIL key_pixel: got %0h want bde", pixel);
    end
`else
    if (pixel !== 12'h0F0) begin
      errors++;
      $display("FAIL key_pixel: got %0h want 0f0", pixel);
    end
`endif
    glyph_en = 1'b0;
  endtask

  task automatic test_aux_blank();
    valid = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0;
    aux_req = 1'b1; aux_sel = 1'b0; aux_addr = 17'd1234;
    tick();
    checks++;
    if (aux_gnt !== 1'b1 || bg_addr !== 17'd1234) begin
      errors++;
      $display("FAIL aux_bg_issue: gnt=%b bg=%0d want 1/1234", aux_gnt, bg_addr);
    end
    aux_req = 1'b0;
    tick();
    checks++;
    if (aux_gnt !== 1'b0 || aux_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL aux_bg_wait: gnt=%b rv=%b want 0/0", aux_gnt, aux_rvalid);
    end
    tick();
    checks++;
    if (aux_rvalid !== 1'b1 || aux_rdata !== 12'h177) begin
      errors++;
      $display("FAIL aux_bg_done: rv=%b rd=%0h want 1/177", aux_rvalid, aux_rdata);
    end
    tick();
    checks++;
    if (aux_rvalid !== 1'b0 || aux_rdata !== 12'h177) begin
      errors++;
      $display("FAIL aux_bg_hold: rv=%b rd=%0h want 0/177", aux_rvalid, aux_rdata);
    end
    aux_req = 1'b1; aux_sel = 1'b1; aux_addr = 17'h00ABC;
    tick();
    checks++;
    if (aux_gnt !== 1'b1 || al_addr !== 16'hABC) begin
      errors++;
      $display("FAIL aux_al_issue: gnt=%b al=%0h want 1/abc", aux_gnt, al_addr);
    end
    aux_req = 1'b0;
    tick();
    tick();
    checks++;
    if (aux_rvalid !== 1'b1 || aux_rdata !== 12'h97F) begin
      errors++;
      $display("FAIL aux_al_done: rv=%b rd=%0h want 1/97f", aux_rvalid, aux_rdata);
    end
    tick();
  endtask

  task automatic test_aux_during_valid();
    int early;
    early = 0;
    h_cnt = 10'd10; v_cnt = 10'd10; valid = 1'b1;
    aux_req = 1'b1; aux_sel = 1'b0; aux_addr = 17'd500;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (aux_gnt !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL aux_blocked_by_valid: gnt seen %0d times want 0", early);
    end
    valid = 1'b0;
    tick();
    checks++;
    if (aux_gnt !== 1'b1 || bg_addr !== 17'd500) begin
      errors++;
      $display("FAIL aux_after_valid: gnt=%b bg=%0d want 1/500", aux_gnt, bg_addr);
    end
    aux_req = 1'b0;
    tick();
    tick();
    checks++;
    if (aux_rvalid !== 1'b1 || aux_rdata !== 12'h451) begin
      errors++;
      $display("FAIL aux_after_valid_done: rv=%b rd=%0h want 1/451", aux_rvalid, aux_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    h_cnt = 10'd2; v_cnt = 10'd0; valid = 1'b0;
    aux_req = 1'b1; aux_sel = 1'b0; aux_addr = 17'd7;
    tick();
    checks++;
    if (aux_gnt !== 1'b1) begin
      errors++;
      $display("FAIL last_blank_issue: gnt=%b want 1", aux_gnt);
    end
    aux_req = 1'b0; valid = 1'b1;
    tick();
    checks++;
    if (bg_addr !== 17'd1) begin
      errors++;
      $display("FAIL display_reclaims: bg=%0d want 1", bg_addr);
    end
    valid = 1'b0;
    tick();
    checks++;
    if (aux_rvalid !== 1'b1 || aux_rdata !== 12'h5A2) begin
      errors++;
      $display("FAIL last_blank_done: rv=%b rd=%0h want 1/5a2", aux_rvalid, aux_rdata);
    end
    tick();
    checks++;
    if (pixel !== 12'h5A4 || pixel_valid !== 1'b1) begin
      errors++;
      $display("FAIL display_unaffected: got %0h/%b want 5a4/1", pixel, pixel_valid);
    end
    aux_req = 1'b1; aux_addr = 17'd9;
    tick();
    tick();
    tick();
    checks++;
    if (aux_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rearb_first_done: rv=%b want 1", aux_rvalid);
    end
    tick();
    checks++;
    if (aux_gnt !== 1'b0 || aux_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rearb_idle: gnt=%b rv=%b want 0/0", aux_gnt, aux_rvalid);
    end
    tick();
    checks++;
    if (aux_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rearb_second_gnt: gnt=%b want 1", aux_gnt);
    end
    aux_req = 1'b0;
    tick();
    tick();
    checks++;
    if (aux_rvalid !== 1'b1 || aux_rdata !== 12'h5AC) begin
      errors++;
      $display("FAIL rearb_second_done: rv=%b rd=%0h want 1/5ac", aux_rvalid, aux_rdata);
    end
    tick();
  endtask

  task automatic test_reset_wait();
    int late;
    late = 0;
    valid = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0;
    aux_req = 1'b1; aux_sel = 1'b1; aux_addr = 17'h00ABC;
    tick();
    aux_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bg_addr, al_addr, aux_gnt, aux_rvalid, aux_rdata,
         pixel, pixel_valid} !== '0) begin
      errors++;
      $display("FAIL reset_in_wait: bg=%0h al=%0h gnt=%b rv=%b rd=%0h px=%0h pv=%b want all 0",
               bg_addr, al_addr, aux_gnt, aux_rvalid, aux_rdata, pixel, pixel_valid);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (aux_rvalid !== 1'b0 || aux_rdata !== 12'h000) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL reset_drops_read: rvalid/rdata nonzero %0d cycles want 0", late);
    end
  endtask

  initial begin
    test_reset();
    test_bg_basic();
    test_bg_edges();
    test_glyph_window();
    test_glyph_limits();
    test_key();
    test_aux_blank();
    test_aux_during_valid();
    test_back_to_back();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
